// File: rtl/ic_req_arbiter_pkg.sv
// Shared definitions for the two-requester peripheral-port arbiter.
//   ic_owner_t  : one-bit requester ID stored in the owner FIFO
//   IC_RQW/RSW  : default request/response payload widths
package ic_req_arbiter_pkg;

    localparam int IC_RQW = 64;
    localparam int IC_RSW = 33;

    typedef logic ic_owner_t;

    localparam ic_owner_t IC_OWNER_M0 = 1'b0;
    localparam ic_owner_t IC_OWNER_M1 = 1'b1;

    function automatic ic_owner_t ic_other(input ic_owner_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ic_req_arbiter_if.sv
// Request/response port bundle: req/gnt/reqdata request channel and
// recv/ack/rspdata response channel.
//   master : requester side (drives req, reqdata, ack)
//   slave  : responder side (drives gnt, recv, rspdata)
interface ic_req_arbiter_if
    import ic_req_arbiter_pkg::*;
#(
    parameter int RQW = IC_RQW,
    parameter int RSW = IC_RSW
) ();

    logic           req;
    logic           gnt;
    logic [RQW-1:0] reqdata;
    logic           recv;
    logic           ack;
    logic [RSW-1:0] rspdata;

    modport master (
        output req, reqdata, ack,
        input  gnt, recv, rspdata
    );

    modport slave (
        input  req, reqdata, ack,
        output gnt, recv, rspdata
    );

endinterface

// File: rtl/ic_req_arbiter_owner_fifo.sv
// In-order owner FIFO: remembers which requester issued each outstanding
// request so responses can be routed back.
//   clk/rst_n : clock, async active-low reset
//   push/din  : enqueue an owner ID
//   pop       : dequeue the head
//   dout      : current head (valid only when count != 0)
//   count     : number of entries held
module ic_owner_fifo
    import ic_req_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap keeps DEPTH==1 correct, where the pointer is wider than needed.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ic_req_arbiter.sv
// Shares one peripheral port between m0 (instruction fetch) and m1 (data).
// Round-robin grants, held while the peripheral stalls; responses are routed
// back in issue order through an owner FIFO. Both channels are pass-through.
//   g_clk/g_resetn : clock, async active-low reset
//   m0, m1         : requester ports
//   s              : shared peripheral port
//   err_stray      : sticky, response seen with nothing outstanding
module ic_req_arbiter
    import ic_req_arbiter_pkg::*;
#(
    parameter int RQW    = IC_RQW,
    parameter int RSW    = IC_RSW,
    parameter int MAX_OS = 2
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    ic_req_arbiter_if.slave  m0,
    ic_req_arbiter_if.slave  m1,
    ic_req_arbiter_if.master s,
    output logic             err_stray
);

    localparam int CW = $clog2(MAX_OS) + 1;

    logic [CW-1:0]  count;
    ic_owner_t      head;
    ic_owner_t      sel;
    ic_owner_t      rr_last;
    ic_owner_t      lock_id;
    logic           lock;
    logic           can_issue;
    logic           sel_req;
    logic           s_req_int;
    logic           s_ack_int;
    logic           push;
    logic           pop;
    logic           empty;
    logic [RQW-1:0] reqdata_mux;
    logic [RSW-1:0] rspdata_fan;

    // Full blocks issue even if a pop lands this cycle, so gnt never depends on s.recv.
    assign can_issue = (count < CW'(MAX_OS));

    always_comb begin
        sel = IC_OWNER_M0;
        if (lock)
            sel = lock_id;
        else if (m0.req && m1.req)
            sel = ic_other(rr_last);
        else if (m1.req)
            sel = IC_OWNER_M1;
    end

    assign sel_req     = (sel == IC_OWNER_M1) ? m1.req : m0.req;
    assign reqdata_mux = (sel == IC_OWNER_M1) ? m1.reqdata : m0.reqdata;
    assign s_req_int   = can_issue && sel_req;
    assign push        = s_req_int && s.gnt;

    assign empty       = (count == '0);
    assign s_ack_int   = !empty && ((head == IC_OWNER_M1) ? m1.ack : m0.ack);
    assign pop         = s.recv && s_ack_int;
    assign rspdata_fan = s.rspdata;

    ic_owner_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OS)
    ) u_owner_fifo (
        .clk   (g_clk),
        .rst_n (g_resetn),
        .push  (push),
        .pop   (pop),
        .din   (sel),
        .dout  (head),
        .count (count)
    );

    // Lock pins the selection to a stalled requester until its handshake.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rr_last   <= IC_OWNER_M1;
            lock      <= 1'b0;
            lock_id   <= IC_OWNER_M0;
            err_stray <= 1'b0;
        end else begin
            if (push) begin
                rr_last <= sel;
                lock    <= 1'b0;
            end else if (s_req_int) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end
            if (s.recv && empty) err_stray <= 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign s.req      = g_resetn && s_req_int;
    assign s.reqdata  = g_resetn ? reqdata_mux : '0;
    assign s.ack      = g_resetn && s_ack_int;
    assign m0.gnt     = g_resetn && push && (sel == IC_OWNER_M0);
    assign m1.gnt     = g_resetn && push && (sel == IC_OWNER_M1);
    assign m0.recv    = g_resetn && s.recv && !empty && (head == IC_OWNER_M0);
    assign m1.recv    = g_resetn && s.recv && !empty && (head == IC_OWNER_M1);
    assign m0.rspdata = g_resetn ? rspdata_fan : '0;
    assign m1.rspdata = g_resetn ? rspdata_fan : '0;

endmodule

// File: tb/tb_ic_req_arbiter.sv
module tb_ic_req_arbiter;
    import ic_req_arbiter_pkg::*;

    localparam int RQW    = IC_RQW;
    localparam int RSW    = IC_RSW;
    localparam int MAX_OS = 2;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    logic err_stray;

    ic_req_arbiter_if #(.RQW(RQW), .RSW(RSW)) m0_if ();
    ic_req_arbiter_if #(.RQW(RQW), .RSW(RSW)) m1_if ();
    ic_req_arbiter_if #(.RQW(RQW), .RSW(RSW)) s_if ();

    ic_req_arbiter #(
        .RQW    (RQW),
        .RSW    (RSW),
        .MAX_OS (MAX_OS)
    ) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .err_stray (err_stray)
    );

    always #5 g_clk = ~g_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of outstanding owners, last granted ID,
    // requester stuck waiting on the peripheral (-1 none), sticky error.
    int q[$];
    int last_id = 1;
    int pend    = -1;
    bit err_m   = 1'b0;
    bit g0_m, g1_m;

    logic obs_sreq, obs_g0, obs_g1, obs_ack, obs_r0, obs_r1;

    logic           rr0, rr1;
    logic [RQW-1:0] rd0, rd1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r0, input logic [RQW-1:0] d0,
                        input logic r1, input logic [RQW-1:0] d1,
                        input logic sg, input logic sr, input logic [RSW-1:0] rsp,
                        input logic a0, input logic a1);
        int  sz, ch, hd;
        bit  allow, emp, e_sreq, e_g0, e_g1, e_r0, e_r1, e_ack;
        logic [RQW-1:0] e_sdata;
        m0_if.req = r0; m0_if.reqdata = d0; m0_if.ack = a0;
        m1_if.req = r1; m1_if.reqdata = d1; m1_if.ack = a1;
        s_if.gnt = sg; s_if.recv = sr; s_if.rspdata = rsp;

        sz    = q.size();
        allow = (sz < MAX_OS);
        if (pend >= 0)      ch = pend;
        else if (r0 && r1)  ch = 1 - last_id;
        else if (r1)        ch = 1;
        else                ch = 0;
        e_sreq  = allow && ((ch == 1) ? r1 : r0);
        e_sdata = (ch == 1) ? d1 : d0;
        e_g0    = e_sreq && sg && (ch == 0);
        e_g1    = e_sreq && sg && (ch == 1);
        emp     = (sz == 0);
        hd      = emp ? 0 : q[0];
        e_r0    = sr && !emp && (hd == 0);
        e_r1    = sr && !emp && (hd == 1);
        e_ack   = !emp && ((hd == 0) ? a0 : a1);

        @(negedge g_clk);
        obs_sreq = s_if.req; obs_g0 = m0_if.gnt; obs_g1 = m1_if.gnt;
        obs_ack = s_if.ack; obs_r0 = m0_if.recv; obs_r1 = m1_if.recv;
        chk("s_req",      64'(obs_sreq),  64'(e_sreq));
        chk("s_reqdata",  s_if.reqdata,   e_sdata);
        chk("m0_gnt",     64'(obs_g0),    64'(e_g0));
        chk("m1_gnt",     64'(obs_g1),    64'(e_g1));
        chk("m0_recv",    64'(obs_r0),    64'(e_r0));
        chk("m1_recv",    64'(obs_r1),    64'(e_r1));
        chk("s_ack",      64'(obs_ack),   64'(e_ack));
        chk("m0_rspdata", 64'(m0_if.rspdata), 64'(rsp));
        chk("m1_rspdata", 64'(m1_if.rspdata), 64'(rsp));
        chk("err_stray",  64'(err_stray), 64'(err_m));
        chk("count",      64'(dut.count), 64'(sz));

        @(posedge g_clk);
        #1;
        if (sr && emp) err_m = 1'b1;
        if (sr && e_ack) void'(q.pop_front());
        if (e_sreq && sg) begin
            q.push_back(ch);
            last_id = ch;
            pend    = -1;
        end else if (e_sreq) begin
            pend = ch;
        end
        g0_m = e_g0;
        g1_m = e_g1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && q.size() > 0; k++)
            step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, RSW'(33'h1_5a5a_0000 + k), 1'b1, 1'b1);
        chk("drain_count", 64'(dut.count), 64'd0);
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        m0_if.req = 1'b1; m0_if.reqdata = '1; m0_if.ack = 1'b1;
        m1_if.req = 1'b1; m1_if.reqdata = '1; m1_if.ack = 1'b1;
        s_if.gnt = 1'b1; s_if.recv = 1'b1; s_if.rspdata = '1;
        #2;
        chk("rst_s_req",      64'(s_if.req),       64'd0);
        chk("rst_s_reqdata",  s_if.reqdata,        64'd0);
        chk("rst_s_ack",      64'(s_if.ack),       64'd0);
        chk("rst_m0_gnt",     64'(m0_if.gnt),      64'd0);
        chk("rst_m1_gnt",     64'(m1_if.gnt),      64'd0);
        chk("rst_m0_recv",    64'(m0_if.recv),     64'd0);
        chk("rst_m1_recv",    64'(m1_if.recv),     64'd0);
        chk("rst_m0_rspdata", 64'(m0_if.rspdata),  64'd0);
        chk("rst_err_stray",  64'(err_stray),      64'd0);
        @(posedge g_clk);
        #1;
        m0_if.req = 1'b0; m1_if.req = 1'b0; s_if.gnt = 1'b0; s_if.recv = 1'b0;
        m0_if.ack = 1'b0; m1_if.ack = 1'b0;
        g_resetn = 1'b1;
        q.delete();
        last_id = 1; pend = -1; err_m = 1'b0; g0_m = 1'b0; g1_m = 1'b0;
    endtask

    localparam logic [RQW-1:0] DA = 64'haaaa_0000_0000_0001;
    localparam logic [RQW-1:0] DB = 64'hbbbb_0000_0000_0002;

    initial begin
        @(posedge g_clk);
        #1;
        do_reset();

        // first request from m0 granted immediately
        step(1'b1, DA, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t1_m0_gnt", 64'(obs_g0), 64'd1);
        chk("t1_m1_gnt", 64'(obs_g1), 64'd0);
        chk("t1_count",  64'(dut.count), 64'd1);
        drain();

        // both requesting continuously: alternating grants, in-order responses
        for (int i = 0; i < 8; i++)
            step(1'b1, DA + i, 1'b1, DB + i, 1'b1, (q.size() > 0), RSW'(i), 1'b1, 1'b1);
        drain();

        // stalled m1 keeps the port while m0 joins
        step(1'b0, '0, 1'b1, DB, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DA, 1'b1, DB, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("t3_locked_data", s_if.reqdata, DB);
        step(1'b1, DA, 1'b1, DB, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t3_m1_gnt", 64'(obs_g1), 64'd1);
        step(1'b1, DA, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t3_m0_gnt", 64'(obs_g0), 64'd1);
        drain();

        // full: no issue until the cycle after a pop
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t4_full", 64'(obs_sreq), 64'd0);
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b1, RSW'(7), 1'b1, 1'b1);
        chk("t4_full_pop", 64'(obs_sreq), 64'd0);
        step(1'b1, DA, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t4_resume", 64'(obs_sreq), 64'd1);
        drain();

        // head-of-line response for m1 blocks m0's response until acked
        step(1'b0, '0, 1'b1, DB, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, DA, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, RSW'(9), 1'b1, 1'b0);
            chk("t5_ack_wait", 64'(obs_ack), 64'd0);
            chk("t5_m0_recv",  64'(obs_r0),  64'd0);
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, RSW'(9), 1'b0, 1'b1);
        chk("t5_m1_recv", 64'(obs_r1), 64'd1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, RSW'(10), 1'b1, 1'b0);
        chk("t5_m0_recv_after", 64'(obs_r0), 64'd1);
        drain();

        // stray response
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, RSW'(3), 1'b1, 1'b1);
        chk("t6_ack", 64'(obs_ack), 64'd0);
        idle();
        chk("t6_err", 64'(err_stray), 64'd1);
        idle();
        idle();
        chk("t6_err_held", 64'(err_stray), 64'd1);
        do_reset();
        chk("t6_err_cleared", 64'(err_stray), 64'd0);

        // randomized traffic honouring hold-until-grant
        rr0 = 1'b0; rr1 = 1'b0; rd0 = '0; rd1 = '0;
        for (int i = 0; i < 3000; i++) begin
            logic sg, sr, a0, a1;
            if (!(rr0 && !g0_m)) begin
                rr0 = ($urandom_range(0, 3) != 0);
                rd0 = {$urandom, $urandom};
            end
            if (!(rr1 && !g1_m)) begin
                rr1 = ($urandom_range(0, 3) != 0);
                rd1 = {$urandom, $urandom};
            end
            sg = ($urandom_range(0, 2) != 0);
            sr = (q.size() > 0) && ($urandom_range(0, 1) != 0);
            a0 = ($urandom_range(0, 3) != 0);
            a1 = ($urandom_range(0, 3) != 0);
            step(rr0, rd0, rr1, rd1, sg, sr, RSW'({$urandom, $urandom}), a0, a1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
